// File: rtl/muldiv_sequencer_if.sv
// EX-stage <-> multiply/divide unit handshake: operation issue, flush, HI/LO
// access hints, and the HI/LO result with its write strobe.
interface muldiv_sequencer_if #(
   parameter int unsigned WIDTH = 32
);
   logic             start;
   logic [1:0]       funct;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cancel;
   logic             hilo_read;
   logic             hilo_write;
   logic             busy;
   logic             stall;
   logic             hilo_we;
   logic [WIDTH-1:0] hi_out;
   logic [WIDTH-1:0] lo_out;

   // EX stage issues operations and consumes results
   modport master (
      output start, funct, a, b, cancel, hilo_read, hilo_write,
      input  busy, stall, hilo_we, hi_out, lo_out
   );

   // muldiv unit
   modport slave (
      input  start, funct, a, b, cancel, hilo_read, hilo_write,
      output busy, stall, hilo_we, hi_out, lo_out
   );
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU unit (shift-add / restoring) with HI/LO interlock.
// Define MULDIV_EARLY_OUT_EN for early multiply exit and a CALC bypass on divide by zero.
module muldiv_sequencer #(
   parameter int unsigned WIDTH = 32
) (
   input  logic              clk,
   input  logic              reset_n,
   muldiv_sequencer_if.slave bus
);
   localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int unsigned DW = 2 * WIDTH;

   localparam logic [2:0] IDLE = 3'd0;
   localparam logic [2:0] PREP = 3'd1;
   localparam logic [2:0] CALC = 3'd2;
   localparam logic [2:0] FIX  = 3'd3;
   localparam logic [2:0] DONE = 3'd4;

   logic [2:0]       state;
   logic [2:0]       state_nxt;
   logic [CW-1:0]    count;
   logic [1:0]       fn_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] mplier;
   logic [DW-1:0]    mcand;
   logic [DW-1:0]    acc;
   logic             neg_res;
   logic             neg_rem;
   logic [WIDTH-1:0] hi_q;
   logic [WIDTH-1:0] lo_q;

   logic             is_div;
   logic             is_signed;
   logic             a_neg;
   logic             b_neg;
   logic [WIDTH-1:0] a_mag;
   logic [WIDTH-1:0] b_mag;
   logic             b_zero;
   logic             last_iter;
   logic [WIDTH-1:0] mplier_shr;
   logic             calc_done;
   logic             div0_skip;
   logic [WIDTH:0]   rem_sh;
   logic [WIDTH:0]   rem_diff;
   logic [DW-1:0]    div_step;
   logic [DW-1:0]    prod;
   logic [WIDTH-1:0] quo_fix;
   logic [WIDTH-1:0] rem_fix;
   logic [WIDTH-1:0] fix_hi;
   logic [WIDTH-1:0] fix_lo;
   logic             busy;

   // Operand decode: funct[1] selects divide, funct[0] selects unsigned
   assign is_div     = fn_q[1];
   assign is_signed  = ~fn_q[0];
   assign a_neg      = is_signed & a_q[WIDTH-1];
   assign b_neg      = is_signed & b_q[WIDTH-1];
   assign a_mag      = a_neg ? -a_q : a_q;
   assign b_mag      = b_neg ? -b_q : b_q;
   assign b_zero     = (b_q == '0);
   assign last_iter  = (count == CW'(WIDTH - 1));
   assign mplier_shr = mplier >> 1;

`ifdef MULDIV_EARLY_OUT_EN
   assign calc_done = last_iter | (~is_div & (mplier_shr == '0));
   assign div0_skip = is_div & b_zero;
`else
   assign calc_done = last_iter;
   assign div0_skip = 1'b0;
`endif

   // Restoring divide step: acc holds {remainder, quotient}, mplier holds the divisor
   assign rem_sh   = {acc[DW-1:WIDTH], acc[WIDTH-1]};
   assign rem_diff = rem_sh - {1'b0, mplier};
   assign div_step = rem_diff[WIDTH]
                   ? {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                   : {rem_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

   // Sign fix: quotient truncates toward zero, remainder follows the dividend
   assign prod    = neg_res ? -acc : acc;
   assign quo_fix = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
   assign rem_fix = neg_rem ? -acc[DW-1:WIDTH] : acc[DW-1:WIDTH];

   always_comb begin
      fix_hi = prod[DW-1:WIDTH];
      fix_lo = prod[WIDTH-1:0];
      if (is_div) begin
         if (b_zero) begin
            fix_hi = a_q;
            fix_lo = '1;
         end else begin
            fix_hi = rem_fix;
            fix_lo = quo_fix;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (bus.start && !bus.cancel) state_nxt = PREP;
         PREP: begin
            if (bus.cancel)     state_nxt = IDLE;
            else if (div0_skip) state_nxt = FIX;
            else                state_nxt = CALC;
         end
         CALC: begin
            if (bus.cancel)     state_nxt = IDLE;
            else if (calc_done) state_nxt = FIX;
         end
         FIX:     state_nxt = bus.cancel ? IDLE : DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Datapath: operand latch, magnitude prep, iterate, register signed result
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count   <= '0;
         fn_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         mplier  <= '0;
         mcand   <= '0;
         acc     <= '0;
         neg_res <= 1'b0;
         neg_rem <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start && !bus.cancel) begin
                  fn_q <= bus.funct;
                  a_q  <= bus.a;
                  b_q  <= bus.b;
               end
            end
            PREP: begin
               mcand   <= {{WIDTH{1'b0}}, a_mag};
               mplier  <= b_mag;
               acc     <= is_div ? {{WIDTH{1'b0}}, a_mag} : '0;
               count   <= '0;
               neg_res <= a_neg ^ b_neg;
               neg_rem <= a_neg;
            end
            CALC: begin
               count <= count + CW'(1);
               if (is_div) begin
                  acc <= div_step;
               end else begin
                  if (mplier[0]) acc <= acc + mcand;
                  mcand  <= mcand << 1;
                  mplier <= mplier_shr;
               end
            end
            FIX: begin
               if (!bus.cancel) begin
                  hi_q <= fix_hi;
                  lo_q <= fix_lo;
               end
            end
            default: ;
         endcase
      end
   end

   assign busy        = (state != IDLE);
   assign bus.busy    = busy;
   assign bus.stall   = busy & (bus.start | bus.hilo_read | bus.hilo_write);
   assign bus.hilo_we = (state == DONE) & ~bus.cancel;
   assign bus.hi_out  = hi_q;
   assign bus.lo_out  = lo_q;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed table, interlock/cancel/reset
// sequences and randomized operations against a 64-bit arithmetic reference.
module tb_muldiv_sequencer;
   localparam int unsigned W = 32;

`ifdef MULDIV_EARLY_OUT_EN
   localparam bit EARLY = 1'b1;
`else
   localparam bit EARLY = 1'b0;
`endif

   logic clk;
   logic reset_n;
   int   total;
   int   bad;

   muldiv_sequencer_if #(.WIDTH(W)) bus ();

   muldiv_sequencer #(.WIDTH(W)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  f;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
   } vec_t;

   vec_t vecs[$];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference result {hi, lo} from plain 64-bit arithmetic
   function automatic logic [63:0] ref_model(input logic [1:0] f, input logic [31:0] av,
                                             input logic [31:0] bv);
      longint sa;
      longint sb;
      logic [63:0] r;
      sa = longint'($signed(av));
      sb = longint'($signed(bv));
      case (f)
         2'd0:    r = 64'(sa * sb);
         2'd1:    r = {32'd0, av} * {32'd0, bv};
         default: begin
            if (bv == 32'd0)     r = {av, 32'hFFFF_FFFF};
            else if (f == 2'd2)  r = {32'(sa % sb), 32'(sa / sb)};
            else                 r = {av % bv, av / bv};
         end
      endcase
      return r;
   endfunction

   // Number of clock edges after the start edge until hilo_we is visible
   function automatic int exp_edge(input logic [1:0] f, input logic [31:0] bv);
      logic [31:0] mag;
      int hb;
      if (!EARLY) return int'(W) + 2;
      if (f[1]) return (bv == 32'd0) ? 2 : int'(W) + 2;
      mag = (!f[0] && bv[31]) ? -bv : bv;
      hb = 0;
      for (int i = 0; i < 32; i++) if (mag[i]) hb = i;
      return hb + 3;
   endfunction

   task automatic wait_we(output int seen);
      seen = -1;
      for (int i = 1; i <= 100; i++) begin
         step();
         if (bus.hilo_we === 1'b1) begin
            seen = i;
            break;
         end
      end
   endtask

   task automatic run_op(input string name, input logic [1:0] f, input logic [31:0] av,
                         input logic [31:0] bv, input logic [31:0] ehi, input logic [31:0] elo);
      int seen;
      bus.funct = f;
      bus.a     = av;
      bus.b     = bv;
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      bus.a     = $urandom();
      bus.b     = $urandom();
      check({name, " busy"}, 64'(bus.busy), 64'd1);
      wait_we(seen);
      check({name, " latency"}, 64'(seen), 64'(exp_edge(f, bv)));
      check({name, " hi"}, 64'(bus.hi_out), 64'(ehi));
      check({name, " lo"}, 64'(bus.lo_out), 64'(elo));
      step();
      check({name, " we_pulse"}, {62'd0, bus.hilo_we, bus.busy}, 64'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, elapsed %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int seen;
      bit flag_ok;
      logic [63:0] r;
      logic [1:0]  rf;
      logic [31:0] ra;
      logic [31:0] rb;

      total = 0;
      bad   = 0;
      vecs.push_back('{2'd0, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA});
      vecs.push_back('{2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001});
      vecs.push_back('{2'd2, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD});
      vecs.push_back('{2'd3, 32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 32'hFFFF_FFFF});
      vecs.push_back('{2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000});
      vecs.push_back('{2'd2, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF});
      vecs.push_back('{2'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000});
      vecs.push_back('{2'd3, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E});
      vecs.push_back('{2'd2, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD});
      vecs.push_back('{2'd1, 32'h0000_0005, 32'h0000_0001, 32'h0000_0000, 32'h0000_0005});
      vecs.push_back('{2'd0, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000});
      vecs.push_back('{2'd3, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0001});

      // Reset state, with requests asserted to show stall stays low while idle
      reset_n        = 1'b0;
      bus.start      = 1'b1;
      bus.funct      = 2'd0;
      bus.a          = 32'd0;
      bus.b          = 32'd0;
      bus.cancel     = 1'b0;
      bus.hilo_read  = 1'b1;
      bus.hilo_write = 1'b1;
      step();
      step();
      check("rst busy", 64'(bus.busy), 64'd0);
      check("rst stall", 64'(bus.stall), 64'd0);
      check("rst hilo_we", 64'(bus.hilo_we), 64'd0);
      check("rst hilo", {bus.hi_out, bus.lo_out}, 64'd0);
      bus.start      = 1'b0;
      bus.hilo_read  = 1'b0;
      bus.hilo_write = 1'b0;
      reset_n        = 1'b1;
      step();

      for (int i = 0; i < vecs.size(); i++)
         run_op($sformatf("vec%0d", i), vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo);

      // start together with cancel while idle is ignored
      bus.start  = 1'b1;
      bus.cancel = 1'b1;
      step();
      check("start_cancel idle", 64'(bus.busy), 64'd0);
      bus.start  = 1'b0;
      bus.cancel = 1'b0;
      step();

      // hilo_read interlock from cycle 5 until the DONE cycle
      bus.funct = 2'd1; bus.a = 32'd3; bus.b = 32'hFFFF_FFFF; bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      flag_ok = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         step();
         if (bus.stall !== 1'b0) flag_ok = 1'b0;
      end
      check("rd no early stall", 64'(flag_ok), 64'd1);
      bus.hilo_read = 1'b1;
      #1;
      flag_ok = (bus.stall === 1'b1);
      seen = -1;
      for (int i = 5; i <= 100; i++) begin
         step();
         if (bus.stall !== 1'b1) flag_ok = 1'b0;
         if (bus.hilo_we === 1'b1) begin
            seen = i;
            break;
         end
      end
      check("rd stall held", 64'(flag_ok), 64'd1);
      check("rd latency", 64'(seen), 64'(exp_edge(2'd1, 32'hFFFF_FFFF)));
      check("rd result", {bus.hi_out, bus.lo_out}, 64'h0000_0002_FFFF_FFFD);
      step();
      check("rd stall drops", 64'(bus.stall), 64'd0);
      bus.hilo_read = 1'b0;

      // Second start held by the stall, accepted on the first idle edge
      bus.funct = 2'd0; bus.a = 32'hFFFF_FFFE; bus.b = 32'd3; bus.start = 1'b1;
      step();
      bus.funct = 2'd1; bus.a = 32'hFFFF_FFFF; bus.b = 32'hFFFF_FFFF;
      flag_ok = (bus.stall === 1'b1);
      seen = -1;
      for (int i = 1; i <= 100; i++) begin
         step();
         if (bus.stall !== 1'b1) flag_ok = 1'b0;
         if (bus.hilo_we === 1'b1) begin
            seen = i;
            break;
         end
      end
      check("b2b stall A", 64'(flag_ok), 64'd1);
      check("b2b latency A", 64'(seen), 64'(exp_edge(2'd0, 32'd3)));
      check("b2b result A", {bus.hi_out, bus.lo_out}, 64'hFFFF_FFFF_FFFF_FFFA);
      step();
      check("b2b idle gap", {62'd0, bus.busy, bus.stall}, 64'd0);
      step();
      bus.start = 1'b0;
      check("b2b B accepted", 64'(bus.busy), 64'd1);
      bus.hilo_write = 1'b1;
      #1;
      check("b2b write stall", 64'(bus.stall), 64'd1);
      bus.hilo_write = 1'b0;
      wait_we(seen);
      check("b2b latency B", 64'(seen), 64'(exp_edge(2'd1, 32'hFFFF_FFFF)));
      check("b2b result B", {bus.hi_out, bus.lo_out}, 64'hFFFF_FFFE_0000_0001);
      step();

      // Cancel mid-operation keeps the previous HI/LO
      run_op("pre_cancel", 2'd3, 32'd100, 32'd7, 32'd2, 32'd14);
      bus.funct = 2'd2; bus.a = 32'hFFFF_FFF9; bus.b = 32'd2; bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      for (int i = 1; i <= 9; i++) step();
      bus.cancel = 1'b1;
      step();
      bus.cancel = 1'b0;
      check("cancel busy", 64'(bus.busy), 64'd0);
      check("cancel hilo", {bus.hi_out, bus.lo_out}, 64'h0000_0002_0000_000E);
      flag_ok = 1'b1;
      for (int i = 0; i < 40; i++) begin
         if (bus.hilo_we !== 1'b0) flag_ok = 1'b0;
         step();
      end
      check("cancel no we", 64'(flag_ok), 64'd1);

      // Cancel in the DONE cycle suppresses the strobe
      bus.funct = 2'd2; bus.a = 32'hFFFF_FFF9; bus.b = 32'd2; bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      wait_we(seen);
      check("cdone reach", 64'(seen), 64'(exp_edge(2'd2, 32'd2)));
      bus.cancel = 1'b1;
      #1;
      check("cdone we", 64'(bus.hilo_we), 64'd0);
      check("cdone busy", 64'(bus.busy), 64'd1);
      step();
      bus.cancel = 1'b0;
      check("cdone idle", {62'd0, bus.busy, bus.hilo_we}, 64'd0);

      // Asynchronous reset in the middle of CALC
      bus.funct = 2'd1; bus.a = 32'd3; bus.b = 32'hFFFF_FFFF; bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      bus.hilo_read = 1'b1;
      for (int i = 0; i < 8; i++) step();
      check("mid stall", 64'(bus.stall), 64'd1);
      #2;
      reset_n = 1'b0;
      #1;
      check("arst flags", {61'd0, bus.busy, bus.stall, bus.hilo_we}, 64'd0);
      check("arst hilo", {bus.hi_out, bus.lo_out}, 64'd0);
      step();
      reset_n = 1'b1;
      bus.hilo_read = 1'b0;
      flag_ok = 1'b1;
      for (int i = 0; i < 40; i++) begin
         step();
         if (bus.hilo_we !== 1'b0 || bus.busy !== 1'b0) flag_ok = 1'b0;
      end
      check("arst quiet", 64'(flag_ok), 64'd1);
      run_op("post_rst", 2'd1, 32'd5, 32'd1, 32'd0, 32'd5);

      // Randomized operations against the arithmetic reference
      for (int i = 0; i < 40; i++) begin
         rf = 2'($urandom_range(0, 3));
         ra = $urandom();
         case ($urandom_range(0, 3))
            0:       rb = 32'd0;
            1:       rb = 32'($urandom_range(1, 15));
            2:       rb = -32'($urandom_range(1, 15));
            default: rb = $urandom();
         endcase
         if ($urandom_range(0, 3) == 0) ra = 32'h8000_0000;
         r = ref_model(rf, ra, rb);
         run_op($sformatf("rnd%0d f%0d a%0h b%0h", i, rf, ra, rb), rf, ra, rb, r[63:32], r[31:0]);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Iterative multi-cycle multiply/divide unit and its controller.
- Executes the MULT, MULTU, DIV and DIVU functions issued by the EX stage.
- Produces a one-cycle HI/LO write strobe on completion.
- Generates the pipeline stall interlock for HI/LO hazards while an operation is in flight.
- Sits beside the ALU in EX; its HI/LO result feeds the HI/LO register write port (hilo_src MULDIV).

Parameters:
- WIDTH, 32, operand width; latency and counter width derive from it (counter is clog2(WIDTH) bits).

Ports:
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- start  in  1  EX holds a valid muldiv instruction this cycle
- funct  in  2  muldiv_funct: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU
- a  in  WIDTH  rs operand
- b  in  WIDTH  rt operand
- cancel  in  1  flush from a later stage; aborts the in-flight operation
- hilo_read  in  1  MFHI/MFLO in EX this cycle
- hilo_write  in  1  MTHI/MTLO in EX this cycle
- busy  out  1  state != IDLE
- stall  out  1  pipeline stall request (combinational)
- hilo_we  out  1  one-cycle write strobe for both HI and LO
- hi_out  out  WIDTH  HI result (remainder or product high half)
- lo_out  out  WIDTH  LO result (quotient or product low half)

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE, counter=0, internal registers=0.
  - hi_out=lo_out=0, hilo_we=0, busy=0, stall=0.
- FSM states: IDLE, PREP, CALC, FIX, DONE.
  - IDLE: on edge with start=1 and cancel=0, latch funct, a, b; go to PREP. start with cancel=1 is ignored.
  - PREP (1 cycle):
    - Signed functs: take magnitudes of a and b, record result sign and remainder sign.
    - Unsigned functs: pass operands through unchanged.
    - Clear accumulator and counter; go to CALC.
  - CALC (WIDTH cycles, counter 0..WIDTH-1):
    - Multiply: shift-add. If the multiplier LSB is set, add the multiplicand (shifted left) into a 2*WIDTH accumulator; then shift the multiplier right.
    - Divide: restoring. Shift the remainder:quotient pair left, trial-subtract the divisor, keep the result if it is non-negative.
    - At counter=WIDTH-1, go to FIX.
  - FIX (1 cycle): apply signs.
    - Signed multiply: negate the product if the result sign is set.
    - Signed divide: quotient truncates toward zero; remainder takes the dividend's sign.
    - Register the result into hi_out/lo_out; go to DONE.
  - DONE (1 cycle): hilo_we=1 unless cancel=1; go to IDLE.
- Latency: start sampled at edge N gives hilo_we=1 during the cycle following edge N+WIDTH+2 (35 cycles for WIDTH=32).
- hi_out/lo_out hold their value until the next FIX.
- Divide by zero (b==0), deterministic result: hi_out=a unmodified, lo_out=all ones, for both DIV and DIVU. FIX skips the sign fix in this case.
- DIV 0x80000000 / 0xFFFFFFFF: lo_out=0x80000000, hi_out=0. No exception.
- stall = busy & (start | hilo_read | hilo_write).
  - A start while busy is held by the stall and accepted on the first IDLE edge.
  - busy stays high through DONE, so a read in the DONE cycle stalls once more.
- cancel:
  - In PREP, CALC or FIX: next state is IDLE; outputs unchanged; no hilo_we.
  - In DONE: suppresses hilo_we.
- Asynchronous reset mid-operation: state returns to IDLE immediately; no hilo_we.

Optional Feature:
- Macro: MULDIV_EARLY_OUT_EN.
- With the macro defined:
  - Multiply leaves CALC after the first iteration in which the remaining (shifted) multiplier is zero. The result is identical.
  - Divide with b==0 goes PREP→FIX directly, skipping CALC.
  - Latency for multiply = 4 + (index of highest set bit of |b|). When |b|==0, CALC lasts 1 cycle.
- Without the macro: fixed latency WIDTH+3 for every operation.

Test Plan:
- MULT a=0xFFFFFFFE (-2), b=0x00000003 → hilo_we at cycle 35, hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001.
- DIV a=0xFFFFFFF9 (-7), b=2 → lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIVU a=7, b=0 → hi=7, lo=0xFFFFFFFF.
- Interlock: start MULT; at cycle 5 assert hilo_read → stall=1 through DONE; stall drops the cycle after hilo_we. A second start during busy is accepted only after IDLE.
- cancel asserted in cycle 10 of a DIV → busy=0 next cycle; no hilo_we; hi/lo keep the prior values. Repeat with cancel in the DONE cycle → hilo_we=0.
- reset_n pulsed low mid-CALC → busy/stall/hilo_we=0 immediately, outputs 0. With MULDIV_EARLY_OUT_EN, MULTU a=5, b=1 → hilo_we at cycle 4, lo=5.
